// File: rtl/legv8_pkg.sv
// Shared LEGv8 decode definitions for the decode-side branch logic.
// Holds the control-flow opcode constants, the condition-code and FSM state
// enums, the machine word / instruction width macros, and small helpers that
// classify an instruction word and sign-extend its branch offsets.
`ifndef WORD
`define WORD 64
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

package legv8_pkg;

  // Major opcodes; B/BL use the top 6 bits, the conditional forms the top 8.
  localparam logic [5:0] OP_B     = 6'b000101;
  localparam logic [5:0] OP_BL    = 6'b100101;
  localparam logic [7:0] OP_CBZ   = 8'b10110100;
  localparam logic [7:0] OP_CBNZ  = 8'b10110101;
  localparam logic [7:0] OP_BCOND = 8'b01010100;

  typedef enum logic [3:0] {
    CondEq = 4'd0,
    CondNe = 4'd1,
    CondHs = 4'd2,
    CondLo = 4'd3,
    CondMi = 4'd4,
    CondPl = 4'd5,
    CondVs = 4'd6,
    CondVc = 4'd7,
    CondHi = 4'd8,
    CondLs = 4'd9,
    CondGe = 4'd10,
    CondLt = 4'd11,
    CondGt = 4'd12,
    CondLe = 4'd13,
    CondAl = 4'd14,
    CondNv = 4'd15
  } cond_e;

  typedef enum logic [1:0] {
    StFill   = 2'd0,
    StRun    = 2'd1,
    StSquash = 2'd2
  } state_e;

  // One-hot-or-zero classification of a control-flow instruction.
  typedef struct packed {
    logic b;
    logic bl;
    logic cbz;
    logic cbnz;
    logic bcond;
  } br_dec_t;

  function automatic br_dec_t decode_branch(input logic [`INSTR_LEN-1:0] instr);
    br_dec_t dec;
    dec.b     = (instr[31:26] == OP_B);
    dec.bl    = (instr[31:26] == OP_BL);
    dec.cbz   = (instr[31:24] == OP_CBZ);
    dec.cbnz  = (instr[31:24] == OP_CBNZ);
    dec.bcond = (instr[31:24] == OP_BCOND);
    return dec;
  endfunction

  // imm26 sign-extended and scaled to a byte offset.
  function automatic logic [`WORD-1:0] offset_imm26(input logic [`INSTR_LEN-1:0] instr);
    return {{(`WORD-28){instr[25]}}, instr[25:0], 2'b00};
  endfunction

  // imm19 (bits 23:5) sign-extended and scaled to a byte offset.
  function automatic logic [`WORD-1:0] offset_imm19(input logic [`INSTR_LEN-1:0] instr);
    return {{(`WORD-21){instr[23]}}, instr[23:5], 2'b00};
  endfunction

endpackage

// File: rtl/branch_redirect_cond_eval.sv
// Condition-code evaluator for B.cond.
// Ports:
//   cond  - 4-bit condition field of the instruction
//   flags - NZCV, N at bit 3, V at bit 0
//   taken - 1 when the condition holds
module cond_eval
  import legv8_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic flag_n;
  logic flag_z;
  logic flag_c;
  logic flag_v;
  logic ge;
  logic hi;
  logic gt;

  assign flag_n = flags[3];
  assign flag_z = flags[2];
  assign flag_c = flags[1];
  assign flag_v = flags[0];
  assign ge     = (flag_n == flag_v);
  assign hi     = flag_c & ~flag_z;
  assign gt     = ~flag_z & ge;

  always_comb begin
    taken = 1'b0;
    unique case (cond_e'(cond))
      CondEq: taken = flag_z;
      CondNe: taken = ~flag_z;
      CondHs: taken = flag_c;
      CondLo: taken = ~flag_c;
      CondMi: taken = flag_n;
      CondPl: taken = ~flag_n;
      CondVs: taken = flag_v;
      CondVc: taken = ~flag_v;
      CondHi: taken = hi;
      CondLs: taken = ~hi;
      CondGe: taken = ge;
      CondLt: taken = ~ge;
      CondGt: taken = gt;
      CondLe: taken = ~gt;
      CondAl: taken = 1'b1;
      CondNv: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_redirect.sv
// Decode-side branch resolution for a LEGv8 pipeline.
// Registers the fetched instruction into the IF/ID register, resolves
// B, BL, CBZ, CBNZ and B.cond in ID, redirects fetch, squashes the single
// wrong-path instruction in the branch shadow and keeps saturating counters.
// Ports:
//   clk, reset      - clock, synchronous active-low reset
//   instruction     - fetched word, aligned with cur_pc
//   cur_pc          - PC of instruction
//   flags           - NZCV from execute
//   rt_zero         - register Rt reads as zero
//   pc_src          - fetch takes branch_target on the next edge
//   branch_target   - redirect address (0 when ID holds no valid branch)
//   id_instr/id_pc  - IF/ID register contents
//   id_valid        - ID entry is real, not a squashed slot
//   link_we         - taken BL in ID, write X30
//   link_data       - id_pc + 4
//   branch_count    - valid control-flow instructions seen (saturating)
//   taken_count     - taken redirects issued (saturating)
`ifndef WORD
`define WORD 64
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module branch_redirect
  import legv8_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [`INSTR_LEN-1:0] instruction,
  input  logic [`WORD-1:0]      cur_pc,
  input  logic [3:0]            flags,
  input  logic                  rt_zero,
  output logic                  pc_src,
  output logic [`WORD-1:0]      branch_target,
  output logic [`INSTR_LEN-1:0] id_instr,
  output logic [`WORD-1:0]      id_pc,
  output logic                  id_valid,
  output logic                  link_we,
  output logic [`WORD-1:0]      link_data,
  output logic [CNT_W-1:0]      branch_count,
  output logic [CNT_W-1:0]      taken_count
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e                  state_q, state_d;
  logic [`INSTR_LEN-1:0]   id_instr_q;
  logic [`WORD-1:0]        id_pc_q;
  logic                    id_valid_q, id_valid_d;
  logic [CNT_W-1:0]        branch_count_q, branch_count_d;
  logic [CNT_W-1:0]        taken_count_q, taken_count_d;

  br_dec_t                 dec;
  logic                    is_branch;
  logic                    cond_taken;
  logic                    taken;
  logic                    br_valid;
  logic [`WORD-1:0]        offset;
  logic [`WORD-1:0]        target;

  // ---------------------------------------------------------------------------
  // Decode and target computation from the ID register
  // ---------------------------------------------------------------------------
  assign dec       = decode_branch(id_instr_q);
  assign is_branch = dec.b | dec.bl | dec.cbz | dec.cbnz | dec.bcond;
  assign br_valid  = id_valid_q & is_branch;

  cond_eval u_cond_eval (
    .cond  (id_instr_q[3:0]),
    .flags (flags),
    .taken (cond_taken)
  );

  always_comb begin
    offset = '0;
    taken  = 1'b0;
    if (dec.b || dec.bl) begin
      offset = offset_imm26(id_instr_q);
      taken  = 1'b1;
    end else if (dec.cbz) begin
      offset = offset_imm19(id_instr_q);
      taken  = rt_zero;
    end else if (dec.cbnz) begin
      offset = offset_imm19(id_instr_q);
      taken  = ~rt_zero;
    end else if (dec.bcond) begin
      offset = offset_imm19(id_instr_q);
      taken  = cond_taken;
    end
  end

  // Modulo 2^WORD addition; wrap-around is intended.
  assign target = id_pc_q + offset;

  assign pc_src        = br_valid & taken;
  assign branch_target = br_valid ? target : '0;
  assign link_we       = pc_src & dec.bl;
  assign link_data     = id_pc_q + `WORD'(4);

  assign id_instr      = id_instr_q;
  assign id_pc         = id_pc_q;
  assign id_valid      = id_valid_q;
  assign branch_count  = branch_count_q;
  assign taken_count   = taken_count_q;

  // ---------------------------------------------------------------------------
  // Pipeline FSM: FILL -> RUN, RUN -(taken)-> SQUASH -> RUN
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    id_valid_d = 1'b1;
    unique case (state_q)
      StFill: begin
        state_d = StRun;
      end
      StRun: begin
        // The word being fetched now is the wrong-path shadow of a taken branch.
        if (pc_src) begin
          id_valid_d = 1'b0;
          state_d    = StSquash;
        end
      end
      StSquash: begin
        state_d = StRun;
      end
      default: begin
        state_d = StFill;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Saturating statistics; squashed slots never reach here since br_valid=0.
  // ---------------------------------------------------------------------------
  always_comb begin
    branch_count_d = branch_count_q;
    taken_count_d  = taken_count_q;
    if (br_valid && branch_count_q != CntMax) begin
      branch_count_d = branch_count_q + CNT_W'(1);
    end
    if (pc_src && taken_count_q != CntMax) begin
      taken_count_d = taken_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= StFill;
      id_instr_q     <= '0;
      id_pc_q        <= '0;
      id_valid_q     <= 1'b0;
      branch_count_q <= '0;
      taken_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      id_instr_q     <= instruction;
      id_pc_q        <= cur_pc;
      id_valid_q     <= id_valid_d;
      branch_count_q <= branch_count_d;
      taken_count_q  <= taken_count_d;
    end
  end

endmodule

// File: tb/tb_branch_redirect.sv
`ifndef WORD
`define WORD 64
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module tb_branch_redirect;

  localparam logic [31:0] NOP = 32'h8B000000;

  logic                  clk;
  logic                  reset;
  logic [`INSTR_LEN-1:0] instruction;
  logic [`WORD-1:0]      cur_pc;
  logic [3:0]            flags;
  logic                  rt_zero;
  logic                  pc_src;
  logic [`WORD-1:0]      branch_target;
  logic [`INSTR_LEN-1:0] id_instr;
  logic [`WORD-1:0]      id_pc;
  logic                  id_valid;
  logic                  link_we;
  logic [`WORD-1:0]      link_data;
  logic [15:0]           branch_count;
  logic [15:0]           taken_count;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0]      exp_bc;
  logic [15:0]      exp_tc;
  logic [`WORD-1:0] fpc;

  branch_redirect #(.CNT_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .instruction   (instruction),
    .cur_pc        (cur_pc),
    .flags         (flags),
    .rt_zero       (rt_zero),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_valid      (id_valid),
    .link_we       (link_we),
    .link_data     (link_data),
    .branch_count  (branch_count),
    .taken_count   (taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [63:0] pc;
    logic [3:0]  flg;
    logic        rtz;
    logic        exp_br;
    logic        exp_src;
    logic [63:0] exp_tgt;
    logic        exp_link;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] instr_at(input logic [63:0] pc);
    return (pc == 64'd12) ? 32'h14000008 : NOP;
  endfunction

  // Fetch-stage model: follows pc_src/branch_target as seen at the edge.
  task automatic fetch_tick();
    logic take;
    logic [63:0] tgt;
    logic rs;
    take = pc_src;
    tgt  = branch_target;
    rs   = reset;
    @(posedge clk);
    #1;
    fpc = !rs ? 64'd0 : (take ? tgt : fpc + 64'd4);
    cur_pc      = fpc;
    instruction = instr_at(fpc);
  endtask

  // Architected cond evaluation: base test from cond[3:1], inverted by cond[0]
  // except for 1111.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cc, v, base;
    n = f[3]; z = f[2]; cc = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cc;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cc && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return (c[0] && c != 4'hF) ? !base : base;
  endfunction

  task automatic apply_vec(input vec_t v);
    instruction = v.instr;
    cur_pc      = v.pc;
    flags       = v.flg;
    rt_zero     = v.rtz;
    tick();
    chk({v.name, " id_valid"}, 64'(id_valid), 64'd1);
    chk({v.name, " pc_src"}, 64'(pc_src), 64'(v.exp_src));
    chk({v.name, " target"}, branch_target, v.exp_tgt);
    chk({v.name, " link_we"}, 64'(link_we), 64'(v.exp_link));
    chk({v.name, " link_data"}, link_data, v.pc + 64'd4);
    if (v.exp_br) exp_bc = exp_bc + 16'd1;
    if (v.exp_src) exp_tc = exp_tc + 16'd1;
    instruction = NOP;
    cur_pc      = v.pc + 64'd4;
    tick();
    chk({v.name, " shadow valid"}, 64'(id_valid), 64'(!v.exp_src));
    chk({v.name, " branch_count"}, 64'(branch_count), 64'(exp_bc));
    chk({v.name, " taken_count"}, 64'(taken_count), 64'(exp_tc));
    tick();
  endtask

  initial begin
    vec_t sv;
    //         name          instr          pc           flg    rtz   br    src   target                 link
    vecs[0]  = '{"b_plus8",    32'h14000008, 64'd12,      4'b0000, 1'b0, 1'b1, 1'b1, 64'd44,                1'b0};
    vecs[1]  = '{"bl_minus2",  32'h97FFFFFE, 64'd48,      4'b0000, 1'b0, 1'b1, 1'b1, 64'd40,                1'b1};
    vecs[2]  = '{"cbz_taken",  32'hB4000100, 64'd20,      4'b0000, 1'b1, 1'b1, 1'b1, 64'd52,                1'b0};
    vecs[3]  = '{"cbz_nt",     32'hB4000100, 64'd20,      4'b0000, 1'b0, 1'b1, 1'b0, 64'd52,                1'b0};
    vecs[4]  = '{"cbnz_taken", 32'hB5000100, 64'd20,      4'b0000, 1'b0, 1'b1, 1'b1, 64'd52,                1'b0};
    vecs[5]  = '{"cbnz_nt",    32'hB5000100, 64'd20,      4'b0000, 1'b1, 1'b1, 1'b0, 64'd52,                1'b0};
    vecs[6]  = '{"beq_taken",  32'h54000040, 64'd32,      4'b0100, 1'b0, 1'b1, 1'b1, 64'd40,                1'b0};
    vecs[7]  = '{"beq_nt",     32'h54000040, 64'd32,      4'b0000, 1'b0, 1'b1, 1'b0, 64'd40,                1'b0};
    vecs[8]  = '{"non_branch", 32'h8B020020, 64'd100,     4'b1111, 1'b1, 1'b0, 1'b0, 64'd0,                 1'b0};
    vecs[9]  = '{"b_wrap",     32'h17FFFFFC, 64'd8,       4'b0000, 1'b0, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFF8,  1'b0};
    vecs[10] = '{"bnv",        32'h5400004F, 64'd32,      4'b0000, 1'b0, 1'b1, 1'b1, 64'd40,                1'b0};
    vecs[11] = '{"cbz_minimm", 32'hB4800000, 64'h100000,  4'b0000, 1'b1, 1'b1, 1'b1, 64'd0,                 1'b0};
    vecs[12] = '{"near_bcond", 32'h55000040, 64'd32,      4'b0100, 1'b0, 1'b0, 1'b0, 64'd0,                 1'b0};

    // Reset held, then release with the fetch model streaming 0,4,8,12(B #8).
    reset = 1'b0; flags = 4'b0000; rt_zero = 1'b0;
    fpc = 64'd0; cur_pc = 64'd0; instruction = instr_at(64'd0);
    fetch_tick();
    fetch_tick();
    chk("rst id_valid", 64'(id_valid), 64'd0);
    chk("rst id_pc", id_pc, 64'd0);
    chk("rst id_instr", 64'(id_instr), 64'd0);
    chk("rst pc_src", 64'(pc_src), 64'd0);
    chk("rst target", branch_target, 64'd0);
    chk("rst branch_count", 64'(branch_count), 64'd0);
    chk("rst taken_count", 64'(taken_count), 64'd0);
    reset = 1'b1;
    fetch_tick();
    chk("fill id_valid", 64'(id_valid), 64'd1);
    chk("fill id_pc", id_pc, 64'd0);
    chk("fill pc_src", 64'(pc_src), 64'd0);
    fetch_tick();
    chk("run id_pc4", id_pc, 64'd4);
    chk("run pc_src4", 64'(pc_src), 64'd0);
    fetch_tick();
    chk("run id_pc8", id_pc, 64'd8);
    chk("run counters", 64'({branch_count, taken_count}), 64'd0);
    fetch_tick();
    chk("seq b id_pc", id_pc, 64'd12);
    chk("seq b pc_src", 64'(pc_src), 64'd1);
    chk("seq b target", branch_target, 64'd44);
    fetch_tick();
    chk("seq squash valid", 64'(id_valid), 64'd0);
    chk("seq squash pc_src", 64'(pc_src), 64'd0);
    fetch_tick();
    chk("seq tgt id_pc", id_pc, 64'd44);
    chk("seq tgt valid", 64'(id_valid), 64'd1);
    chk("seq taken_count", 64'(taken_count), 64'd1);
    chk("seq branch_count", 64'(branch_count), 64'd1);
    exp_bc = 16'd1;
    exp_tc = 16'd1;

    // Directed decode vectors.
    for (int i = 0; i < 13; i++) apply_vec(vecs[i]);

    // B.cond sweep over every cond code and flag value.
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        sv.name     = $sformatf("bcond c%0d f%0d", c, f);
        sv.instr    = 32'h54000040 | 32'(c);
        sv.pc       = 64'd32;
        sv.flg      = 4'(f);
        sv.rtz      = 1'b0;
        sv.exp_br   = 1'b1;
        sv.exp_src  = ref_cond(4'(c), 4'(f));
        sv.exp_tgt  = 64'd40;
        sv.exp_link = 1'b0;
        apply_vec(sv);
      end
    end

    // Reset asserted in the SQUASH slot.
    instruction = 32'h14000008; cur_pc = 64'd12;
    tick();
    chk("sqrst pc_src", 64'(pc_src), 64'd1);
    instruction = NOP; cur_pc = 64'd16;
    tick();
    chk("sqrst in squash", 64'(id_valid), 64'd0);
    reset = 1'b0; cur_pc = 64'd44;
    tick();
    chk("sqrst id_valid", 64'(id_valid), 64'd0);
    chk("sqrst pc_src0", 64'(pc_src), 64'd0);
    chk("sqrst id_pc", id_pc, 64'd0);
    chk("sqrst branch_count", 64'(branch_count), 64'd0);
    chk("sqrst taken_count", 64'(taken_count), 64'd0);
    reset = 1'b1; cur_pc = 64'd200;
    tick();
    chk("sqrst fill valid", 64'(id_valid), 64'd1);
    chk("sqrst fill id_pc", id_pc, 64'd200);

    // Saturation: stream not-taken CBZ; count after E edges is E-1.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    instruction = 32'hB4000100; cur_pc = 64'd20; rt_zero = 1'b0;
    repeat (65535) tick();
    chk("sat pre", 64'(branch_count), 64'hFFFE);
    tick();
    chk("sat reach", 64'(branch_count), 64'hFFFF);
    repeat (4) tick();
    chk("sat hold", 64'(branch_count), 64'hFFFF);
    chk("sat taken0", 64'(taken_count), 64'd0);
    rt_zero = 1'b1;
    #1;
    chk("sat pc_src", 64'(pc_src), 64'd1);
    tick();
    chk("sat hold taken", 64'(branch_count), 64'hFFFF);
    chk("sat taken1", 64'(taken_count), 64'd1);
    chk("sat squash", 64'(id_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_redirect.md
Name: branch_redirect

Overview:
- Decode-side partner of the fetch stage. Consumes `instruction` and `cur_pc` from the fetch stage and registers them into an IF/ID pipeline register.
- Decodes the LEGv8 control-flow formats B, BL, CBZ, CBNZ and B.cond, and drives `pc_src` and `branch_target` back into the fetch stage.
- Squashes the wrong-path instruction fetched in the branch shadow and keeps saturating branch statistics for the lab report.

Parameters:
- CNT_W, 16, width of the branch-statistics counters.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset. Sampled on the rising edge of clk; 0 = reset.
- instruction  input  `INSTR_LEN  instruction word from fetch, aligned with cur_pc.
- cur_pc  input  `WORD  PC of `instruction`.
- flags  input  4  NZCV from the execute stage, with N at bit 3 and V at bit 0.
- rt_zero  input  1  the register read for Rt (bits 4:0) equals zero.
- pc_src  output  1  1 = fetch loads branch_target on the next edge.
- branch_target  output  `WORD  redirect address.
- id_instr  output  `INSTR_LEN  registered instruction.
- id_pc  output  `WORD  registered PC.
- id_valid  output  1  id_instr is a real (non-squashed) instruction.
- link_we  output  1  BL in ID, taken: write X30.
- link_data  output  `WORD  id_pc + 4.
- branch_count  output  CNT_W  valid control-flow instructions seen.
- taken_count  output  CNT_W  taken redirects issued.

Behaviour:
- Reset (reset==0 at an edge) sets:
  - id_instr=0, id_pc=0, id_valid=0;
  - both counters to 0;
  - state=FILL.
- All outputs derived from the ID registers are therefore 0 during and after reset.
- States: FILL, RUN, SQUASH.
- FILL:
  - Covers the first edge after reset releases.
  - Latches instruction/cur_pc with id_valid=1, then goes to RUN.
- RUN:
  - Each edge latches instruction/cur_pc with id_valid=1.
  - If pc_src==1 at that edge, it latches with id_valid=0 instead and goes to SQUASH.
- SQUASH:
  - Lasts exactly one cycle. id_valid=0 in this state, so pc_src=0.
  - The next edge latches the instruction at branch_target with id_valid=1 and returns to RUN.
- Net cost per taken branch: one bubble.
- Decode from id_instr:
  - B: bits 31:26=000101.
  - BL: bits 31:26=100101.
  - CBZ: bits 31:24=10110100.
  - CBNZ: bits 31:24=10110101.
  - B.cond: bits 31:24=01010100, with cond in bits 3:0.
  - Anything else is a non-branch.
- Offsets:
  - B/BL use imm26 = bits 25:0.
  - CBZ/CBNZ/B.cond use imm19 = bits 23:5.
  - The offset is sign-extended to `WORD, shifted left 2, and added to id_pc. Arithmetic is modulo 2^`WORD (wrap-around, no error).
- Taken:
  - B and BL: always taken.
  - CBZ: taken when rt_zero=1.
  - CBNZ: taken when rt_zero=0.
  - B.cond, per cond code:
    - EQ: Z; NE: !Z.
    - HS: C; LO: !C.
    - MI: N; PL: !N.
    - VS: V; VC: !V.
    - HI: C&!Z; LS: !(C&!Z).
    - GE: N==V; LT: N!=V.
    - GT: !Z&(N==V); LE: !GT.
    - AL and NV: always taken.
- Combinational outputs:
  - pc_src = id_valid & is_branch & taken.
  - branch_target = the computed target whenever id_valid & is_branch, else 0.
  - link_we = pc_src & BL.
  - link_data = id_pc+4.
- Statistics:
  - On each edge where id_valid & is_branch, branch_count increments. It saturates at all-ones.
  - taken_count increments when pc_src=1, with the same saturation.
  - Squashed entries never count.
- Simultaneous events: reset overrides everything, including a pending pc_src. A branch in the SQUASH slot is impossible because id_valid=0 there.
- Reset mid-operation (including during SQUASH) discards the ID contents and returns to FILL.

Decomposition:
- Shared package `legv8_pkg` holds:
  - opcode constants (OP_B, OP_BL, OP_CBZ, OP_CBNZ, OP_BCOND);
  - the cond-code enum (EQ..NV);
  - the FSM state enum;
  - the `WORD / `INSTR_LEN macros, already shared.
- One sub-module, `cond_eval`: combinational (cond[3:0], flags) -> taken.

Test Plan:
- Reset held 1 cycle, then released with fetch streaming PC 0,4,8 -> cycle after release: id_valid=1, id_pc=0; next cycle id_pc=4; pc_src=0 throughout; counters 0.
- id_instr=0x14000008 (B #8) at PC 12 -> pc_src=1, branch_target=44. Next cycle id_valid=0 (SQUASH). Cycle after that: id_pc=44, id_valid=1, taken_count=1, branch_count=1.
- 0x97FFFFFE (BL -2) at PC 48 -> branch_target=40, link_we=1, link_data=52.
- 0xB4000100 (CBZ +8) at PC 20:
  - rt_zero=1 -> target 52, pc_src=1.
  - rt_zero=0 -> pc_src=0, no bubble, branch_count increments, taken_count does not.
- 0x54000040 (B.EQ +2) at PC 32:
  - flags=0100 (Z set) -> target 40, taken.
  - flags=0000 -> not taken.
  - Sweep all 16 cond codes against all 16 flag values versus a reference model.
- Reset asserted during the SQUASH cycle -> next cycle id_valid=0, state FILL, counters 0, pc_src=0. Also preset branch_count to all-ones via 65535 branches -> it holds at 0xFFFF.
